fifo_wr_arb: RTL and testbench

- Round-robin burst arbiter that lets REQ_NUM producers share the write port of one sync_fifo instance.
- Each producer drives a valid/ready stream with a last flag. The arbiter grants one producer per burst.
- Accepted beats are tagged {id, last, data} and pass through one registered output stage into the FIFO write port.
- Grants are throttled by the FIFO almost-full flag. Beats stall on FIFO full.

---
 rtl/fifo_wr_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 35 +++
 rtl/fifo_wr_arb.sv | 181 ++++++++++++++++++
 tb/tb_fifo_wr_arb.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared state encoding, statistics width and {id, last, data} tag layout
// for fifo_wr_arb and its round-robin picker.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned STAT_WTH     = 16;
  localparam int unsigned TAG_DATA_LSB = 0;

  function automatic int unsigned tag_last_bit(input int unsigned data_wth);
    return data_wth;
  endfunction

  function automatic int unsigned tag_id_lsb(input int unsigned data_wth);
    return data_wth + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i,
// searching upward with wrap. Returns one-hot, index and any-valid.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] vld_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_oh_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         any_o
);

  int unsigned k;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < N; i++) begin
      // ptr_i < N, so one subtraction is enough to wrap
      k = 32'(ptr_i) + i;
      if (k >= N) begin
        k = k - N;
      end
      if (!any_o && vld_i[k[W-1:0]]) begin
        any_o               = 1'b1;
        gnt_idx_o           = k[W-1:0];
        gnt_oh_o[k[W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port among REQ_NUM producers.
// Optional per-requester beat statistics enabled by FIFO_WR_ARB_STAT_EN.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM   = 4,
  parameter int unsigned REQ_WTH   = 2,
  parameter int unsigned DATA_WTH  = 8,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned BURST_WTH = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [REQ_NUM-1:0]                req_vld_i,
  input  logic [REQ_NUM-1:0]                req_last_i,
  input  logic [REQ_NUM*DATA_WTH-1:0]       req_data_i,
  output logic [REQ_NUM-1:0]                req_rdy_o,
  output logic [REQ_WTH+1+DATA_WTH-1:0]     fifo_wr_data_o,
  output logic                              fifo_wr_en_o,
  input  logic                              fifo_full_i,
  input  logic                              fifo_a_full_i,
  output logic                              busy_o,
  input  logic                              stat_clr_i,
  output logic [REQ_NUM*STAT_WTH-1:0]       stat_cnt_o
);

  localparam int unsigned TAG_WTH  = REQ_WTH + 1 + DATA_WTH;
  localparam int unsigned LAST_BIT = tag_last_bit(DATA_WTH);
  localparam int unsigned ID_LSB   = tag_id_lsb(DATA_WTH);

  arb_state_e           state_q, state_d;
  logic [REQ_WTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [REQ_WTH-1:0]   owner_q, owner_d;
  logic [BURST_WTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 stage_vld_q, stage_vld_d;
  logic [TAG_WTH-1:0]   stage_data_q, stage_data_d;

  logic [REQ_NUM-1:0]   unused_pick_oh;
  logic [REQ_WTH-1:0]   pick_idx;
  logic                 pick_any;

  logic                 sel_vld;
  logic                 sel_last;
  logic [DATA_WTH-1:0]  sel_data;
  logic                 grant_rdy;
  logic                 accept;
  logic                 wr_en;
  logic [BURST_WTH-1:0] beat_inc;
  logic [REQ_WTH-1:0]   owner_nxt;

  rr_pick #(
    .N (REQ_NUM),
    .W (REQ_WTH)
  ) u_rr_pick (
    .vld_i     (req_vld_i),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (unused_pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (owner_q == REQ_WTH'(i)) begin
        sel_vld  = req_vld_i[i];
        sel_last = req_last_i[i];
        sel_data = req_data_i[i*DATA_WTH +: DATA_WTH];
      end
    end
  end

  // A held grant only stalls on a full FIFO when the stage is occupied
  assign grant_rdy = (state_q == GRANT) && (!stage_vld_q || !fifo_full_i);
  assign accept    = grant_rdy && sel_vld;
  assign wr_en     = stage_vld_q && !fifo_full_i;
  assign beat_inc  = beat_cnt_q + BURST_WTH'(1);
  assign owner_nxt = (owner_q == REQ_WTH'(REQ_NUM - 1)) ? '0 : owner_q + REQ_WTH'(1);

  always_comb begin
    req_rdy_o = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      req_rdy_o[i] = grant_rdy && (owner_q == REQ_WTH'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any && !fifo_a_full_i) begin
          state_d    = GRANT;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          beat_cnt_d = beat_inc;
          if (sel_last || (beat_inc == BURST_WTH'(MAX_BURST))) begin
            state_d  = IDLE;
            rr_ptr_d = owner_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stage_vld_d  = stage_vld_q;
    stage_data_d = stage_data_q;
    if (accept) begin
      stage_vld_d                               = 1'b1;
      stage_data_d[ID_LSB +: REQ_WTH]           = owner_q;
      stage_data_d[LAST_BIT]                    = sel_last;
      stage_data_d[TAG_DATA_LSB +: DATA_WTH]    = sel_data;
    end else if (wr_en) begin
      stage_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      beat_cnt_q   <= '0;
      stage_vld_q  <= 1'b0;
      stage_data_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      beat_cnt_q   <= beat_cnt_d;
      stage_vld_q  <= stage_vld_d;
      stage_data_q <= stage_data_d;
    end
  end

  assign fifo_wr_en_o   = wr_en;
  assign fifo_wr_data_o = stage_data_q;
  assign busy_o         = (state_q == GRANT) || stage_vld_q;

`ifdef FIFO_WR_ARB_STAT_EN
  logic [REQ_NUM-1:0][STAT_WTH-1:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (stat_clr_i) begin
      stat_d = '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
        if ((owner_q == REQ_WTH'(i)) && (stat_q[i] != '1)) begin
          stat_d[i] = stat_q[i] + STAT_WTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt_o = stat_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign stat_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: per-scenario tasks with a write-side
// scoreboard fed in the order the arbitration rules dictate.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int BW = 5;
  localparam int TW = IW + 1 + DW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_vld_i = '0;
  logic [N-1:0]      req_last_i = '0;
  logic [N*DW-1:0]   req_data_i = '0;
  logic [N-1:0]      req_rdy_o;
  logic [TW-1:0]     fifo_wr_data_o;
  logic              fifo_wr_en_o;
  logic              fifo_full_i = 1'b0;
  logic              fifo_a_full_i = 1'b0;
  logic              busy_o;
  logic              stat_clr_i = 1'b0;
  logic [N*16-1:0]   stat_cnt_o;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .REQ_NUM   (N),
    .REQ_WTH   (IW),
    .DATA_WTH  (DW),
    .MAX_BURST (MB),
    .BURST_WTH (BW)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_vld_i      (req_vld_i),
    .req_last_i     (req_last_i),
    .req_data_i     (req_data_i),
    .req_rdy_o      (req_rdy_o),
    .fifo_wr_data_o (fifo_wr_data_o),
    .fifo_wr_en_o   (fifo_wr_en_o),
    .fifo_full_i    (fifo_full_i),
    .fifo_a_full_i  (fifo_a_full_i),
    .busy_o         (busy_o),
    .stat_clr_i     (stat_clr_i),
    .stat_cnt_o     (stat_cnt_o)
  );

  int tests = 0;
  int fails = 0;

  logic [TW-1:0] exp_q[$];
  logic [DW:0]   src_mem [N][64];
  int            src_wr [N];
  int            src_rd [N];

  logic [N-1:0]  obs_rdy;
  logic          obs_wr_en;
  logic          obs_busy;
  logic [TW-1:0] obs_data;

  function automatic logic [TW-1:0] tag(input int k, input logic last, input logic [DW-1:0] d);
    return {IW'(k), last, d};
  endfunction

  task automatic clear_src();
    for (int k = 0; k < N; k++) begin
      src_wr[k] = 0;
      src_rd[k] = 0;
    end
  endtask

  task automatic push_beat(input int k, input logic last, input logic [DW-1:0] d);
    src_mem[k][src_wr[k]] = {last, d};
    src_wr[k]++;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (src_rd[k] < src_wr[k]) begin
        req_vld_i[k]              = 1'b1;
        req_last_i[k]             = src_mem[k][src_rd[k]][DW];
        req_data_i[k*DW +: DW]    = src_mem[k][src_rd[k]][DW-1:0];
      end else begin
        req_vld_i[k]              = 1'b0;
        req_last_i[k]             = 1'b0;
        req_data_i[k*DW +: DW]    = '0;
      end
    end
  endtask

  // One clock: sample at negedge, score writes, advance producers after posedge
  task automatic step();
    logic [N-1:0]  acc;
    logic [TW-1:0] e;
    @(negedge clk);
    obs_rdy   = req_rdy_o;
    obs_wr_en = fifo_wr_en_o;
    obs_busy  = busy_o;
    obs_data  = fifo_wr_data_o;
    acc       = req_vld_i & req_rdy_o;
    if (fifo_wr_en_o) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: got %h, required no write", fifo_wr_data_o);
      end else begin
        e = exp_q.pop_front();
        if (fifo_wr_data_o !== e) begin
          fails++;
          $display("FAIL wr_data: got %h, required %h", fifo_wr_data_o, e);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) src_rd[k]++;
    end
    drive();
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    fifo_full_i   = 1'b0;
    fifo_a_full_i = 1'b0;
    stat_clr_i    = 1'b0;
    clear_src();
    drive();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_empty(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_leftover: got %0d beats outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_src();
    push_beat(0, 1'b1, 8'h5A);
    drive();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({req_rdy_o, fifo_wr_en_o, busy_o} !== '0 || fifo_wr_data_o !== '0 || stat_cnt_o !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b en=%b busy=%b data=%h stat=%h, required all 0",
               req_rdy_o, fifo_wr_en_o, busy_o, fifo_wr_data_o, stat_cnt_o);
    end
    clear_src();
    drive();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [N-1:0] rdy_tab [6];
    logic         en_tab  [6];
    logic [DW-1:0] d;
    rdy_tab = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    en_tab  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      d = DW'($urandom_range(0, 255));
      push_beat(2, (i == 2), d);
      exp_q.push_back(tag(2, (i == 2), d));
    end
    drive();
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (obs_rdy !== rdy_tab[i] || obs_wr_en !== en_tab[i]) begin
        fails++;
        $display("FAIL single_c%0d: got rdy=%b en=%b, required rdy=%b en=%b",
                 i, obs_rdy, obs_wr_en, rdy_tab[i], en_tab[i]);
      end
    end
    tests++;
    if (obs_busy !== 1'b0) begin
      fails++;
      $display("FAIL single_busy: got %b, required 0", obs_busy);
    end
    check_empty("single");
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] d;
    logic [N-1:0]  er;
    apply_reset();
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < N; k++) begin
        d = DW'($urandom_range(0, 255));
        push_beat(k, 1'b1, d);
        exp_q.push_back(tag(k, 1'b1, d));
      end
    end
    drive();
    for (int i = 0; i < 16; i++) begin
      step();
      er = (i % 2 == 1) ? N'(1 << (((i - 1) / 2) % N)) : '0;
      tests++;
      if (obs_rdy !== er) begin
        fails++;
        $display("FAIL rr_c%0d: got rdy=%b, required %b", i, obs_rdy, er);
      end
    end
    repeat (4) step();
    check_empty("rr");
  endtask

  task automatic test_max_burst();
    logic [DW-1:0] d1 [20];
    logic [DW-1:0] d2;
    logic [N-1:0]  er;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      d1[i] = DW'($urandom_range(0, 255));
      push_beat(1, (i == 19), d1[i]);
    end
    d2 = DW'($urandom_range(0, 255));
    push_beat(2, 1'b1, d2);
    for (int i = 0; i < MB; i++) exp_q.push_back(tag(1, 1'b0, d1[i]));
    exp_q.push_back(tag(2, 1'b1, d2));
    for (int i = MB; i < 20; i++) exp_q.push_back(tag(1, (i == 19), d1[i]));
    drive();
    for (int i = 0; i < 19; i++) begin
      step();
      er = (i >= 1 && i <= MB) ? 4'b0010 : (i == MB + 2) ? 4'b0100 : 4'b0000;
      tests++;
      if (obs_rdy !== er) begin
        fails++;
        $display("FAIL maxburst_c%0d: got rdy=%b, required %b", i, obs_rdy, er);
      end
    end
    repeat (10) step();
    check_empty("maxburst");
  endtask

  task automatic test_full_stall();
    logic [DW-1:0] d [8];
    logic [TW-1:0] held;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      d[i] = DW'($urandom_range(0, 255));
      push_beat(0, (i == 7), d[i]);
      exp_q.push_back(tag(0, (i == 7), d[i]));
    end
    held = tag(0, 1'b0, d[2]);
    drive();
    repeat (4) step();
    fifo_full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (obs_wr_en !== 1'b0 || obs_rdy !== '0 || obs_data !== held) begin
        fails++;
        $display("FAIL stall_c%0d: got en=%b rdy=%b data=%h, required en=0 rdy=0 data=%h",
                 i, obs_wr_en, obs_rdy, obs_data, held);
      end
    end
    fifo_full_i = 1'b0;
    repeat (12) step();
    check_empty("stall");
  endtask

  task automatic test_a_full();
    logic [DW-1:0] d;
    apply_reset();
    fifo_a_full_i = 1'b1;
    d = DW'($urandom_range(0, 255));
    push_beat(0, 1'b1, d);
    exp_q.push_back(tag(0, 1'b1, d));
    drive();
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (obs_rdy !== '0 || obs_busy !== 1'b0) begin
        fails++;
        $display("FAIL afull_hold_c%0d: got rdy=%b busy=%b, required 0 0", i, obs_rdy, obs_busy);
      end
    end
    fifo_a_full_i = 1'b0;
    step();
    tests++;
    if (obs_rdy !== 4'b0000) begin
      fails++;
      $display("FAIL afull_fall: got rdy=%b, required 0000", obs_rdy);
    end
    step();
    tests++;
    if (obs_rdy !== 4'b0001) begin
      fails++;
      $display("FAIL afull_grant: got rdy=%b, required 0001", obs_rdy);
    end
    repeat (3) step();
    check_empty("afull");
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] d [6];
    logic [DW-1:0] d2, e0, e3;
    apply_reset();
    d2 = DW'($urandom_range(0, 255));
    push_beat(2, 1'b1, d2);
    exp_q.push_back(tag(2, 1'b1, d2));
    for (int i = 0; i < 6; i++) begin
      d[i] = DW'($urandom_range(0, 255));
      push_beat(3, (i == 5), d[i]);
    end
    exp_q.push_back(tag(3, 1'b0, d[0]));
    exp_q.push_back(tag(3, 1'b0, d[1]));
    drive();
    repeat (6) step();
    check_empty("midrst_pre");
    rst_n = 1'b0;
    #1;
    tests++;
    if ({req_rdy_o, fifo_wr_en_o, busy_o} !== '0 || fifo_wr_data_o !== '0 || stat_cnt_o !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: got rdy=%b en=%b busy=%b data=%h stat=%h, required all 0",
               req_rdy_o, fifo_wr_en_o, busy_o, fifo_wr_data_o, stat_cnt_o);
    end
    clear_src();
    exp_q.delete();
    e0 = DW'($urandom_range(0, 255));
    e3 = DW'($urandom_range(0, 255));
    push_beat(0, 1'b1, e0);
    push_beat(3, 1'b1, e3);
    exp_q.push_back(tag(0, 1'b1, e0));
    exp_q.push_back(tag(3, 1'b1, e3));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
    step();
    step();
    tests++;
    if (obs_rdy !== 4'b0001) begin
      fails++;
      $display("FAIL midrst_first_grant: got rdy=%b, required 0001", obs_rdy);
    end
    repeat (6) step();
    check_empty("midrst");
  endtask

  task automatic test_stats();
    logic [DW-1:0] d;
    logic [N*16-1:0] es;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      d = DW'($urandom_range(0, 255));
      push_beat(0, (i == 2), d);
      exp_q.push_back(tag(0, (i == 2), d));
    end
    for (int i = 0; i < 2; i++) begin
      d = DW'($urandom_range(0, 255));
      push_beat(1, (i == 1), d);
      exp_q.push_back(tag(1, (i == 1), d));
    end
    drive();
    repeat (14) step();
    check_empty("stats");
`ifdef FIFO_WR_ARB_STAT_EN
    es = {16'd0, 16'd0, 16'd2, 16'd3};
`else
    es = '0;
`endif
    tests++;
    if (stat_cnt_o !== es) begin
      fails++;
      $display("FAIL stat_count: got %h, required %h", stat_cnt_o, es);
    end
    stat_clr_i = 1'b1;
    step();
    stat_clr_i = 1'b0;
    tests++;
    if (stat_cnt_o !== '0) begin
      fails++;
      $display("FAIL stat_clear: got %h, required 0", stat_cnt_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_max_burst();
    test_full_stall();
    test_a_full();
    test_reset_mid_burst();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
